// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential add/shift multiplier.
// Controller state encoding and counter sizing live here.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Narrowest operand width the datapath supports.
  localparam int MIN_WIDTH = 2;

  function automatic int cnt_w(input int width);
    return (width < MIN_WIDTH) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/add_shift_ctrl.sv
// Controller for the add/shift multiplier.
// Owns the state register, iteration counter and handshake status.
module add_shift_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic ready,
  output logic busy,
  output logic done,
  output logic accept,
  output logic last
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;

  assign ready  = (r_state == IDLE);
  assign busy   = (r_state == ITER);
  assign done   = (r_state == DONE);
  assign accept = ready & start;
  assign last   = busy & (r_cnt == CNT_LAST);

  // State sequencing; the counter holds on the final iteration so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= ITER;
            r_cnt   <= '0;
          end
        end
        ITER: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/add_shift_mult_seq.sv
// Sequential W x W -> 2W add/shift multiplier, signed or unsigned.
// Product lands in {Preg, Areg}; the last signed step subtracts B.
module add_shift_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   ABus,
  input  logic [WIDTH-1:0]   BBus,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] resultBus
);

  if (WIDTH < MIN_WIDTH) begin : g_bad_width
    $error("add_shift_mult_seq: WIDTH must be >= 2");
  end

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic             r_mode;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_p_ext;
  logic [WIDTH:0]   w_addend;
  logic [WIDTH:0]   w_sum;

  add_shift_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .accept (w_accept),
    .last   (w_last)
  );

  assign w_b_ext = r_mode ? {r_b[WIDTH-1], r_b} : {1'b0, r_b};
  assign w_p_ext = r_mode ? {r_p[WIDTH-1], r_p} : {1'b0, r_p};

  // Sign bit of a two's-complement multiplier carries negative weight.
  always_comb begin
    w_addend = '0;
    if (r_a[0]) begin
      w_addend = (r_mode && w_last) ? -w_b_ext : w_b_ext;
    end
  end

  assign w_sum     = w_p_ext + w_addend;
  assign resultBus = {r_p, r_a};

  // Operand capture on accept, then one add/shift step per busy cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
      r_mode <= 1'b0;
    end else if (w_accept) begin
      r_a    <= ABus;
      r_b    <= BBus;
      r_p    <= '0;
      r_mode <= signed_mode & SIGNED_EN;
    end else if (busy) begin
      r_p <= w_sum[WIDTH:1];
      r_a <= {w_sum[0], r_a[WIDTH-1:1]};
    end
  end

endmodule
